// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 1-bit 4:1 multiplexer.
//   Four requesters contend for the mux. One requester is granted at a time,
//   for at most MAX_HOLD cycles. The block drives the mux select and returns
//   the registered mux output together with a valid strobe. One dead (GAP)
//   cycle separates consecutive grants, so the select never changes while
//   the data is valid.
//
// Parameters
//   MAX_HOLD    maximum consecutive GRANT cycles per grant (1..255)
//   CNT_W       hold counter width, 2**CNT_W >= MAX_HOLD
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   req[3:0]    req[i]=1 : requester i wants the mux
//   din[3:0]    din[i]   : data bit of requester i (mux data input i)
//   gnt[3:0]    one-hot grant or all zero, registered
//   sel[1:0]    mux select = index of current/last grantee, registered
//   dout        registered mux output din[sel]
//   dout_valid  dout holds a bit sampled during an active grant
//   busy        1 whenever the FSM is not IDLE, registered
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       dout,
  output logic       dout_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       sel_nxt;
  logic             dout_nxt;
  logic             valid_nxt;
  logic             busy_nxt;

  logic             found;
  logic [1:0]       pick;
  logic             grant_done;

  // Rotating priority scan: ptr has the highest priority, then ptr+1, ...
  // The loop runs from lowest to highest priority, so the last hit wins.
  // NOTE: every variable written in a combinational block gets a default
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        found = 1'b1;
        pick  = ptr + 2'(i);
      end
    end
  end

  // A grant ends when its owner lets go or when it has used its last cycle.
  assign grant_done = (state == GRANT) && (!req[sel] || (hold_cnt == HOLD_LAST));

  // State register and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      hold_cnt   <= '0;
      gnt        <= 4'd0;
      sel        <= 2'd0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      hold_cnt   <= hold_nxt;
      gnt        <= gnt_nxt;
      sel        <= sel_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, GAP: state_nxt = found ? GRANT : IDLE;
      GRANT:     state_nxt = grant_done ? GAP : GRANT;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output and datapath logic, computing the next value of every registered
  // output. gnt and sel hold their values unless arbitration or exit
  // changes them.
  always_comb begin
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    valid_nxt = (state == GRANT) && req[sel];
    dout_nxt  = valid_nxt ? din[sel] : dout;
    // busy is registered, so it follows the state being entered.
    busy_nxt  = (state_nxt != IDLE);

    unique case (state)
      IDLE, GAP: begin
        if (found) begin
          gnt_nxt  = 4'b0001 << pick;
          sel_nxt  = pick;
          hold_nxt = '0;
        end
      end
      GRANT: begin
        // The exit at HOLD_LAST fires before the counter can wrap.
        hold_nxt = hold_cnt + CNT_W'(1);
        if (grant_done) begin
          gnt_nxt = 4'd0;
          ptr_nxt = sel + 2'd1;
        end
      end
      default: begin
        gnt_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Three arbiters with MAX_HOLD = 8, 2 and 1 share one set of inputs.
//   The directed tasks check fixed expected sequences. test_random compares
//   every output of all three instances, on every cycle, with a behavioural
//   model. The model tracks only "who owns the mux, for how long, and where
//   the scan starts".
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] din = 4'd0;

  logic [3:0] gnt_o   [3];
  logic [1:0] sel_o   [3];
  logic       dout_o  [3];
  logic       valid_o [3];
  logic       busy_o  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_h8 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .dout(dout_o[0]),
    .dout_valid(valid_o[0]), .busy(busy_o[0]));

  mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_h2 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .dout(dout_o[1]),
    .dout_valid(valid_o[1]), .busy(busy_o[1]));

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_o[2]), .sel(sel_o[2]), .dout(dout_o[2]),
    .dout_valid(valid_o[2]), .busy(busy_o[2]));

  // ---------------- behavioural reference model ----------------
  int         hlim [3] = '{8, 2, 1};
  int         m_owner [3];   // -1 : nobody owns the mux
  int         m_held  [3];
  int         m_ptr   [3];
  logic [3:0] e_gnt   [3];
  logic [1:0] e_sel   [3];
  logic       e_dout  [3];
  logic       e_valid [3];
  logic       e_busy  [3];

  task automatic model_update();
    int k;
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        m_owner[m] = -1; m_held[m] = 0; m_ptr[m] = 0;
        e_gnt[m] = 4'd0; e_sel[m] = 2'd0; e_dout[m] = 1'b0;
        e_valid[m] = 1'b0; e_busy[m] = 1'b0;
      end else if (m_owner[m] >= 0) begin
        e_valid[m] = req[m_owner[m]];
        if (req[m_owner[m]]) e_dout[m] = din[m_owner[m]];
        m_held[m] = m_held[m] + 1;
        if (!req[m_owner[m]] || m_held[m] == hlim[m]) begin
          m_ptr[m]   = (m_owner[m] + 1) % 4;
          m_owner[m] = -1;
          e_gnt[m]   = 4'd0;
        end
        e_busy[m] = 1'b1;    // either still granted or in the dead cycle
      end else begin
        e_valid[m] = 1'b0;
        k = -1;
        for (int j = 0; j < 4; j++)
          if (k < 0 && req[(m_ptr[m] + j) % 4]) k = (m_ptr[m] + j) % 4;
        if (k >= 0) begin
          m_owner[m] = k; m_held[m] = 0;
          e_gnt[m] = 4'(1 << k); e_sel[m] = 2'(k); e_busy[m] = 1'b1;
        end else begin
          e_busy[m] = 1'b0;
        end
      end
    end
  endtask

  // One clock: the model sees the same inputs the DUT samples at the edge.
  // Outputs are then settled for sampling, 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req = 4'hF; din = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step();
      for (int m = 0; m < 3; m++) begin
        total++;
        if (gnt_o[m] !== 4'd0 || sel_o[m] !== 2'd0 || valid_o[m] !== 1'b0 ||
            busy_o[m] !== 1'b0) begin
          bad++;
          $display("FAIL reset_hold inst%0d cyc%0d: got gnt=%b sel=%0d valid=%b busy=%b want 0000/0/0/0",
                   m, c, gnt_o[m], sel_o[m], valid_o[m], busy_o[m]);
        end
      end
    end
    rst = 1'b0;
    step();
    for (int m = 0; m < 3; m++) begin
      total++;
      if (gnt_o[m] !== 4'b0001 || busy_o[m] !== 1'b1) begin
        bad++;
        $display("FAIL reset_first_grant inst%0d: got gnt=%b busy=%b want 0001/1",
                 m, gnt_o[m], busy_o[m]);
      end
    end
  endtask

  task automatic test_single();
    logic v;
    do_reset();
    req = 4'b0100; din = 4'd0;
    step();
    total++;
    if (gnt_o[0] !== 4'b0100 || sel_o[0] !== 2'd2) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b sel=%0d want 0100/2", gnt_o[0], sel_o[0]);
    end
    for (int j = 0; j < 8; j++) begin
      v = ~j[0];
      din = {1'($urandom), v, 2'($urandom)};
      step();
      total++;
      if (valid_o[0] !== 1'b1 || dout_o[0] !== v ||
          gnt_o[0] !== ((j < 7) ? 4'b0100 : 4'b0000) || busy_o[0] !== 1'b1) begin
        bad++;
        $display("FAIL single_data j=%0d: got gnt=%b dout=%b valid=%b busy=%b want gnt=%b dout=%b valid=1 busy=1",
                 j, gnt_o[0], dout_o[0], valid_o[0], busy_o[0],
                 (j < 7) ? 4'b0100 : 4'b0000, v);
      end
    end
    din = 4'b1011;    // din[2]=0: dout must keep the last sampled bit
    step();
    total++;
    if (gnt_o[0] !== 4'b0100 || sel_o[0] !== 2'd2 || valid_o[0] !== 1'b0 ||
        dout_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_regrant: got gnt=%b sel=%0d valid=%b dout=%b want 0100/2/0/0",
               gnt_o[0], sel_o[0], valid_o[0], dout_o[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    int owner;
    do_reset();
    req = 4'hF;
    for (int e = 1; e <= 15; e++) begin
      step();
      owner = ((e - 1) / 3) % 4;
      want  = (((e - 1) % 3) < 2) ? 4'(1 << owner) : 4'd0;
      total++;
      if (gnt_o[1] !== want || sel_o[1] !== 2'(owner)) begin
        bad++;
        $display("FAIL round_robin e=%0d: got gnt=%b sel=%0d want gnt=%b sel=%0d",
                 e, gnt_o[1], sel_o[1], want, owner);
      end
    end
  endtask

  task automatic test_early_release();
    int nvalid;
    do_reset();
    req = 4'b0010; din = 4'b0010;
    step();
    nvalid = 0;
    for (int j = 0; j < 2; j++) begin
      step();
      if (valid_o[0] === 1'b1) nvalid++;
    end
    req = 4'b1001;    // requester 1 lets go in its 3rd grant cycle
    step();
    if (valid_o[0] === 1'b1) nvalid++;
    total++;
    if (nvalid !== 2 || gnt_o[0] !== 4'd0 || busy_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL early_release: got valid_cycles=%0d gnt=%b busy=%b want 2/0000/1",
               nvalid, gnt_o[0], busy_o[0]);
    end
    req = 4'b1011;
    step();
    total++;
    if (gnt_o[0] !== 4'b1000 || sel_o[0] !== 2'd3) begin
      bad++;
      $display("FAIL early_next_grant: got gnt=%b sel=%0d want 1000/3", gnt_o[0], sel_o[0]);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000; din = 4'hF;
    step();
    for (int j = 0; j < 3; j++) step();
    rst = 1'b1;       // 4th grant cycle of requester 3
    step();
    total++;
    if (gnt_o[0] !== 4'd0 || valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 ||
        sel_o[0] !== 2'd0 || dout_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_grant: got gnt=%b valid=%b busy=%b sel=%0d dout=%b want 0000/0/0/0/0",
               gnt_o[0], valid_o[0], busy_o[0], sel_o[0], dout_o[0]);
    end
    rst = 1'b0; req = 4'hF;
    step();
    total++;
    if (gnt_o[0] !== 4'b0001) begin
      bad++;
      $display("FAIL reset_mid_regrant: got gnt=%b want 0001", gnt_o[0]);
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    req = 4'b0001; din = 4'b0000;
    step();               // pulse cycle 1 -> grant
    din = 4'b0000;
    step();               // pulse cycle 2 samples din[0]=0
    din = 4'b0001;
    step();               // pulse cycle 3 samples din[0]=1
    req = 4'b0000; din = 4'b0000;
    step();               // release seen -> GAP
    total++;
    if (busy_o[0] !== 1'b1 || valid_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_gap: got busy=%b valid=%b want 1/0", busy_o[0], valid_o[0]);
    end
    step();               // -> IDLE
    total++;
    if (busy_o[0] !== 1'b0 || sel_o[0] !== 2'd0 || dout_o[0] !== 1'b1 ||
        gnt_o[0] !== 4'd0) begin
      bad++;
      $display("FAIL idle_return: got busy=%b sel=%0d dout=%b gnt=%b want 0/0/1/0000",
               busy_o[0], sel_o[0], dout_o[0], gnt_o[0]);
    end
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din = 4'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      step();
      for (int m = 0; m < 3; m++) begin
        total++;
        if (gnt_o[m] !== e_gnt[m] || sel_o[m] !== e_sel[m] || dout_o[m] !== e_dout[m] ||
            valid_o[m] !== e_valid[m] || busy_o[m] !== e_busy[m]) begin
          bad++;
          $display("FAIL random c=%0d inst%0d: got gnt=%b sel=%0d dout=%b valid=%b busy=%b want gnt=%b sel=%0d dout=%b valid=%b busy=%b",
                   c, m, gnt_o[m], sel_o[m], dout_o[m], valid_o[m], busy_o[m],
                   e_gnt[m], e_sel[m], e_dout[m], e_valid[m], e_busy[m]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_reset_mid_grant();
    test_idle_return();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
